// File: rtl/ucsbece154b_perf_pkg.sv
// Shared constants for the dual-issue performance monitor: opcodes, the NOP encoding,
// the counter select map and the FSM state encoding.
package ucsbece154b_perf_pkg;

  localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
  localparam logic [6:0]  OP_JAL       = 7'b1101111;
  localparam logic [6:0]  OP_JALR      = 7'b1100111;
  localparam logic [31:0] DEF_NOP_WORD = 32'h00000013;

  typedef enum logic [2:0] {
    SEL_CYCLE  = 3'd0,
    SEL_INSTR  = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_BMISS  = 3'd3,
    SEL_JUMP   = 3'd4,
    SEL_JMISS  = 3'd5,
    SEL_SLOT2  = 3'd6,
    SEL_DUAL   = 3'd7
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A decode slot carries real work unless it holds a bubble (all zeros) or the canonical NOP.
  function automatic logic is_real_instr(input logic [31:0] instr, input logic [31:0] nop);
    return (instr != 32'd0) && (instr != nop);
  endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating event counter: adds 0..2 per cycle, sticks at all-ones, synchronous clear.
module ucsbece154b_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc};
    cnt_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ucsbece154b_perf_monitor.sv
// Performance monitor for the dual-issue core: event counters, halt/timeout detection and
// a registered read port. Optional PERF_SLOT_SPLIT_EN adds slot-2 and dual-issue counters.
module ucsbece154b_perf_monitor
  import ucsbece154b_perf_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          MAX_CYCLES = 500,
  parameter logic [31:0] NOP_WORD   = DEF_NOP_WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             stall_i,
  input  logic [31:0]      InstrD_i,
  input  logic [31:0]      InstrD2_i,
  input  logic [6:0]       opE_i,
  input  logic [6:0]       opE2_i,
  input  logic             Mispredict_i,
  input  logic             Mispredict2_i,
  input  logic             BranchTakenF_i,
  input  logic             BranchTakenF2_i,
  input  logic [31:0]      PCF_i,
  input  logic [31:0]      PCF2_i,
  input  logic [31:0]      InstrF_i,
  input  logic [31:0]      InstrF2_i,
  input  logic [2:0]       sel_i,
  output logic [CNT_W-1:0] rdata_o,
  output logic             done_o,
  output logic             timeout_o
);

  state_e           state_q, state_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      prev_pc1_q, prev_pc1_d, prev_pc2_q, prev_pc2_d;
  logic             prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0] rdata_q;

  logic             run, halt, limit;
  logic             q1, q2, br1, br2, jmp1, jmp2;
  logic [1:0]       inc_w [6];
  logic [CNT_W-1:0] cnt_w [8];

  assign run   = (state_q == ST_RUN);
  assign q1    = is_real_instr(InstrD_i,  NOP_WORD) && !stall_i;
  assign q2    = is_real_instr(InstrD2_i, NOP_WORD) && !stall_i;
  assign br1   = (opE_i  == OP_BRANCH);
  assign br2   = (opE2_i == OP_BRANCH);
  assign jmp1  = (opE_i  == OP_JAL) || (opE_i  == OP_JALR);
  assign jmp2  = (opE2_i == OP_JAL) || (opE2_i == OP_JALR);
  assign limit = (cnt_w[SEL_CYCLE] == CNT_W'(MAX_CYCLES - 1));

  // Both fetch slots parked on the same PC and fetching NOPs means the program spins on halt.
  assign halt = prev_valid_q
             && (PCF_i  == prev_pc1_q) && (InstrF_i  == NOP_WORD)
             && (PCF2_i == prev_pc2_q) && (InstrF2_i == NOP_WORD);

  always_comb begin
    for (int i = 0; i < 6; i++) inc_w[i] = 2'd0;
    if (run) begin
      inc_w[SEL_CYCLE]  = 2'd1;
      inc_w[SEL_INSTR]  = {1'b0, q1} + {1'b0, q2};
      inc_w[SEL_BRANCH] = {1'b0, br1} + {1'b0, br2};
      inc_w[SEL_BMISS]  = {1'b0, br1 && Mispredict_i} + {1'b0, br2 && Mispredict2_i};
      inc_w[SEL_JUMP]   = {1'b0, jmp1} + {1'b0, jmp2};
      inc_w[SEL_JMISS]  = {1'b0, jmp1 && !BranchTakenF_i} + {1'b0, jmp2 && !BranchTakenF2_i};
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_cnt
    ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_i),
      .inc   (inc_w[gi]),
      .cnt   (cnt_w[gi])
    );
  end

`ifdef PERF_SLOT_SPLIT_EN
  logic [1:0] inc_slot2, inc_dual;
  assign inc_slot2 = {1'b0, run && q2};
  assign inc_dual  = {1'b0, run && q1 && q2};

  ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt_slot2 (
    .clk (clk), .reset (reset), .clr (clear_i), .inc (inc_slot2), .cnt (cnt_w[SEL_SLOT2])
  );
  ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt_dual (
    .clk (clk), .reset (reset), .clr (clear_i), .inc (inc_dual), .cnt (cnt_w[SEL_DUAL])
  );
`else
  assign cnt_w[SEL_SLOT2] = '0;
  assign cnt_w[SEL_DUAL]  = '0;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // FSM: next state; clear overrides a simultaneous halt or timeout
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_RUN;
      ST_RUN: begin
        if (halt || limit) state_d = ST_DONE;
        if (limit) timeout_d = 1'b1;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b0;
    end
  end

  // FSM: outputs
  always_comb begin
    done_o    = (state_q == ST_DONE);
    timeout_o = (state_q == ST_DONE) && timeout_q;
  end

  always_comb begin
    prev_pc1_d   = prev_pc1_q;
    prev_pc2_d   = prev_pc2_q;
    prev_valid_d = prev_valid_q;
    if (clear_i) begin
      prev_pc1_d   = '0;
      prev_pc2_d   = '0;
      prev_valid_d = 1'b0;
    end else if (run) begin
      prev_pc1_d   = PCF_i;
      prev_pc2_d   = PCF2_i;
      prev_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_pc1_q   <= '0;
      prev_pc2_q   <= '0;
      prev_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      prev_pc1_q   <= prev_pc1_d;
      prev_pc2_q   <= prev_pc2_d;
      prev_valid_q <= prev_valid_d;
      rdata_q      <= cnt_w[sel_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Directed self-checking bench for ucsbece154b_perf_monitor (honours PERF_SLOT_SPLIT_EN).
module tb_ucsbece154b_perf_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_i = 1'b0, clear_i = 1'b0, stall_i = 1'b0;
  logic [31:0] InstrD_i = 32'h13, InstrD2_i = 32'h13;
  logic [6:0]  opE_i = 7'd0, opE2_i = 7'd0;
  logic        Mispredict_i = 1'b0, Mispredict2_i = 1'b0;
  logic        BranchTakenF_i = 1'b1, BranchTakenF2_i = 1'b1;
  logic [31:0] PCF_i = 32'd0, PCF2_i = 32'd4, InstrF_i = 32'd0, InstrF2_i = 32'd0;
  logic [2:0]  sel_i = 3'd0;
  logic [31:0] rdata_o;
  logic        done_o, timeout_o;

  logic        sc_clr = 1'b1;
  logic [1:0]  sc_inc = 2'd0;
  logic [2:0]  sc_cnt;

  int checks = 0;
  int errors = 0;
  bit pc_hold = 1'b0;

`ifdef PERF_SLOT_SPLIT_EN
  localparam int EXP_SPLIT = 5;
`else
  localparam int EXP_SPLIT = 0;
`endif

  always #5 clk = ~clk;

  ucsbece154b_perf_monitor dut (
    .clk (clk), .reset (reset), .en_i (en_i), .clear_i (clear_i), .stall_i (stall_i),
    .InstrD_i (InstrD_i), .InstrD2_i (InstrD2_i), .opE_i (opE_i), .opE2_i (opE2_i),
    .Mispredict_i (Mispredict_i), .Mispredict2_i (Mispredict2_i),
    .BranchTakenF_i (BranchTakenF_i), .BranchTakenF2_i (BranchTakenF2_i),
    .PCF_i (PCF_i), .PCF2_i (PCF2_i), .InstrF_i (InstrF_i), .InstrF2_i (InstrF2_i),
    .sel_i (sel_i), .rdata_o (rdata_o), .done_o (done_o), .timeout_o (timeout_o)
  );

  ucsbece154b_sat_counter #(.W(3)) u_sat (
    .clk (clk), .reset (reset), .clr (sc_clr), .inc (sc_inc), .cnt (sc_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // One clock: PCs advance unless held, then sample point is the following falling edge.
  task automatic cyc();
    if (!pc_hold) begin
      PCF_i  = PCF_i + 32'd8;
      PCF2_i = PCF_i + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] s, input string tag, input logic [31:0] exp);
    sel_i = s;
    cyc();
    check(tag, rdata_o, exp);
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0; InstrD_i = 32'h13; InstrD2_i = 32'h13;
    opE_i = 7'd0; opE2_i = 7'd0; Mispredict_i = 1'b0; Mispredict2_i = 1'b0;
    BranchTakenF_i = 1'b1; BranchTakenF2_i = 1'b1; InstrF_i = 32'd0; InstrF2_i = 32'd0;
  endtask

  // Clear, then one edge to leave IDLE; afterwards every edge is a counting RUN edge.
  task automatic start();
    idle_inputs();
    clear_i = 1'b1; cyc();
    clear_i = 1'b0; en_i = 1'b1; cyc();
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check("reset_rdata", rdata_o, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_timeout", {31'd0, timeout_o}, 32'd0);

    // Saturating counter boundary: 3-bit, +2 per cycle
    sc_clr = 1'b0; sc_inc = 2'd2;
    cyc(); check("sat_2", 32'(sc_cnt), 32'd2);
    cyc(); check("sat_4", 32'(sc_cnt), 32'd4);
    cyc(); check("sat_6", 32'(sc_cnt), 32'd6);
    cyc(); check("sat_top", 32'(sc_cnt), 32'd7);
    cyc(); check("sat_hold", 32'(sc_cnt), 32'd7);
    sc_inc = 2'd1;
    cyc(); check("sat_hold1", 32'(sc_cnt), 32'd7);
    sc_clr = 1'b1;
    cyc(); check("sat_clr", 32'(sc_cnt), 32'd0);
    check("idle_no_count", rdata_o, 32'd0);

    // A: 10 cycles, both slots real, no stall
    start();
    for (int i = 0; i < 10; i++) begin
      InstrD_i = 32'h00100093 + 32'(i << 20); InstrD2_i = 32'h00200113 + 32'(i << 20);
      cyc();
    end
    idle_inputs();
    rd(3'd0, "A_cycle", 32'd10);
    rd(3'd1, "A_instr", 32'd20);

    // B: same with 4 stalled cycles
    start();
    for (int i = 0; i < 10; i++) begin
      stall_i = (i < 4);
      InstrD_i = 32'h00100093 + 32'(i << 20); InstrD2_i = 32'h00200113 + 32'(i << 20);
      cyc();
    end
    idle_inputs();
    rd(3'd1, "B_instr", 32'd12);
    rd(3'd0, "B_cycle", 32'd11);

    // C: branches in both slots, then a mispredicted jal
    start();
    opE_i = 7'b1100011; opE2_i = 7'b1100011;
    for (int i = 0; i < 3; i++) begin
      Mispredict_i = (i == 1);
      cyc();
    end
    Mispredict_i = 1'b0; opE_i = 7'b1101111; opE2_i = 7'd0; BranchTakenF_i = 1'b0;
    cyc();
    idle_inputs();
    rd(3'd2, "C_branch", 32'd6);
    rd(3'd3, "C_bmiss", 32'd1);
    rd(3'd4, "C_jump", 32'd1);
    rd(3'd5, "C_jmiss", 32'd1);
    opE2_i = 7'b1100111; BranchTakenF2_i = 1'b1;
    cyc();
    idle_inputs();
    rd(3'd4, "C_jump2", 32'd2);
    rd(3'd5, "C_jmiss2", 32'd1);

    // D: halt detection, freeze in DONE, then clear back to IDLE
    start();
    cyc(); cyc(); cyc();
    pc_hold = 1'b1; PCF_i = 32'h40; PCF2_i = 32'h44; InstrF_i = 32'h13; InstrF2_i = 32'h13;
    cyc();
    check("D_not_yet", {31'd0, done_o}, 32'd0);
    cyc();
    check("D_done", {31'd0, done_o}, 32'd1);
    check("D_timeout", {31'd0, timeout_o}, 32'd0);
    rd(3'd0, "D_cycle", 32'd5);
    cyc(); cyc();
    rd(3'd0, "D_frozen", 32'd5);
    pc_hold = 1'b0; InstrF_i = 32'd0; InstrF2_i = 32'd0;
    en_i = 1'b0; clear_i = 1'b1; cyc(); clear_i = 1'b0;
    for (int s = 0; s < 8; s++) rd(3'(s), $sformatf("D_clr_sel%0d", s), 32'd0);
    check("D_clr_done", {31'd0, done_o}, 32'd0);

    // E: timeout after exactly 500 RUN cycles, then async reset in DONE and mid-RUN
    start();
    for (int i = 0; i < 499; i++) cyc();
    check("E_not_yet", {31'd0, done_o}, 32'd0);
    cyc();
    check("E_done", {31'd0, done_o}, 32'd1);
    check("E_timeout", {31'd0, timeout_o}, 32'd1);
    rd(3'd0, "E_cycle", 32'd500);
    #2 reset = 1'b1;
    #1;
    check("E_rst_rdata", rdata_o, 32'd0);
    check("E_rst_done", {31'd0, done_o}, 32'd0);
    check("E_rst_timeout", {31'd0, timeout_o}, 32'd0);
    @(negedge clk); reset = 1'b0;
    start();
    sel_i = 3'd0;
    for (int i = 0; i < 5; i++) cyc();
    check("E_run_rdata", rdata_o, 32'd4);
    #2 reset = 1'b1;
    #1;
    check("E_midrun_rdata", rdata_o, 32'd0);
    @(negedge clk); reset = 1'b0; en_i = 1'b0;
    rd(3'd0, "E_midrun_cnt", 32'd0);

    // F: slot split counters
    start();
    for (int i = 0; i < 8; i++) begin
      InstrD_i = 32'h00500093 + 32'(i << 20);
      InstrD2_i = (i == 5 || i == 6) ? 32'h13 : 32'h00a00113;
      stall_i = (i == 7);
      cyc();
    end
    idle_inputs();
    rd(3'd6, "F_slot2", 32'(EXP_SPLIT));
    rd(3'd7, "F_dual", 32'(EXP_SPLIT));
    rd(3'd1, "F_instr", 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
